// File: rtl/dc_blocker_mc.sv
// Multi-channel DC-blocking high-pass, y(n) = x(n) - x(n-1) + K*y(n-1), K = 1 - 2^-K_SHIFT.
// Channels are processed one per clock after each audio_trigger; the frame is published atomically.
module dc_blocker_mc #(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 16,
  parameter int K_SHIFT   = 7,
  parameter int FRAC_BITS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    audio_trigger,
  input  logic                    clear_in,
  input  logic                    bypass_in,
  input  logic [NUM_CH*WIDTH-1:0] signal_in,
  output logic [NUM_CH*WIDTH-1:0] signal_out,
  output logic                    out_valid,
  output logic                    busy_out,
  output logic                    overrun_out
);

  localparam int Y_W   = WIDTH + FRAC_BITS;
  localparam int S_W   = Y_W + 2;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [S_W-1:0] Y_MAX = {3'b000, {(Y_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] Y_MIN = {3'b111, {(Y_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PROC = 1'b1
  } state_t;

  // Clamp the wide accumulator into the signed Y_W-bit state range.
  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [S_W-1:0] a);
    logic signed [Y_W-1:0] r;
    if (a > Y_MAX) begin
      r = Y_MAX[Y_W-1:0];
    end else if (a < Y_MIN) begin
      r = Y_MIN[Y_W-1:0];
    end else begin
      r = a[Y_W-1:0];
    end
    return r;
  endfunction

  state_t                    state_r;
  state_t                    state_nx_s;
  logic [IDX_W-1:0]          ch_idx_r;
  logic                      bypass_r;
  logic signed [WIDTH-1:0]   frame_r  [NUM_CH];
  logic signed [WIDTH-1:0]   x_prev_r [NUM_CH];
  logic signed [Y_W-1:0]     y_prev_r [NUM_CH];
  logic signed [WIDTH-1:0]   shadow_r [NUM_CH];
  logic [NUM_CH*WIDTH-1:0]   signal_out_r;
  logic                      out_valid_r;
  logic                      overrun_r;

  logic signed [WIDTH-1:0]   x_cur_s;
  logic signed [WIDTH-1:0]   x_old_s;
  logic signed [Y_W-1:0]     y_old_s;
  logic signed [S_W-1:0]     xs_s;
  logic signed [S_W-1:0]     xps_s;
  logic signed [S_W-1:0]     ye_s;
  logic signed [S_W-1:0]     leak_s;
  logic signed [S_W-1:0]     acc_s;
  logic signed [Y_W-1:0]     y_new_s;
  logic signed [WIDTH-1:0]   out_s;
  logic                      last_s;
  logic                      accept_s;

  assign last_s   = (ch_idx_r == IDX_W'(NUM_CH - 1));
  assign accept_s = (state_r == ST_IDLE) && audio_trigger;

  // Per-channel datapath for the channel selected by ch_idx_r.
  always_comb begin
    x_cur_s = frame_r[ch_idx_r];
    x_old_s = x_prev_r[ch_idx_r];
    y_old_s = y_prev_r[ch_idx_r];
    xs_s    = {{(S_W-WIDTH){x_cur_s[WIDTH-1]}}, x_cur_s} <<< FRAC_BITS;
    xps_s   = {{(S_W-WIDTH){x_old_s[WIDTH-1]}}, x_old_s} <<< FRAC_BITS;
    ye_s    = {{2{y_old_s[Y_W-1]}}, y_old_s};
    leak_s  = ye_s - (ye_s >>> K_SHIFT);
    acc_s   = xs_s - xps_s + leak_s;
    if (bypass_r) begin
      y_new_s = '0;
      out_s   = x_cur_s;
    end else begin
      y_new_s = sat_y(acc_s);
      out_s   = y_new_s[Y_W-1:FRAC_BITS];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; clear forces IDLE regardless of trigger.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (audio_trigger) begin
          state_nx_s = ST_PROC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PROC: begin
        if (last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_PROC;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
    if (clear_in) begin
      state_nx_s = ST_IDLE;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // Frame capture, per-channel history update, frame publish and overrun flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ch_idx_r     <= '0;
      bypass_r     <= 1'b0;
      signal_out_r <= '0;
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        frame_r[c]  <= '0;
        x_prev_r[c] <= '0;
        y_prev_r[c] <= '0;
        shadow_r[c] <= '0;
      end
    end else if (clear_in) begin
      ch_idx_r     <= '0;
      bypass_r     <= 1'b0;
      signal_out_r <= '0;
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        x_prev_r[c] <= '0;
        y_prev_r[c] <= '0;
        shadow_r[c] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      if (accept_s) begin
        bypass_r <= bypass_in;
        ch_idx_r <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          frame_r[c] <= signal_in[c*WIDTH +: WIDTH];
        end
      end else if (state_r == ST_PROC) begin
        x_prev_r[ch_idx_r] <= x_cur_s;
        y_prev_r[ch_idx_r] <= y_new_s;
        shadow_r[ch_idx_r] <= out_s;
        if (audio_trigger) begin
          overrun_r <= 1'b1;
        end
        if (last_s) begin
          // The last channel bypasses the shadow so the whole frame lands in one edge.
          ch_idx_r    <= '0;
          out_valid_r <= 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            signal_out_r[c*WIDTH +: WIDTH] <= (IDX_W'(c) == ch_idx_r) ? out_s : shadow_r[c];
          end
        end else begin
          ch_idx_r <= ch_idx_r + IDX_W'(1);
        end
      end
    end
  end

  assign signal_out  = signal_out_r;
  assign out_valid   = out_valid_r;
  assign busy_out    = (state_r == ST_PROC);
  assign overrun_out = overrun_r;

endmodule

// File: tb/tb_dc_blocker_mc.sv
// Self-checking bench for dc_blocker_mc: directed scenarios plus randomized frames
// compared against an arithmetic reference of the filter equation.
module tb_dc_blocker_mc;

  localparam int NC = 2;
  localparam int W  = 16;
  localparam int KS = 7;
  localparam int FB = 8;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              audio_trigger = 1'b0;
  logic              clear_in = 1'b0;
  logic              bypass_in = 1'b0;
  logic [NC*W-1:0]   signal_in = '0;
  logic [NC*W-1:0]   signal_out;
  logic              out_valid;
  logic              busy_out;
  logic              overrun_out;

  dc_blocker_mc #(.NUM_CH(NC), .WIDTH(W), .K_SHIFT(KS), .FRAC_BITS(FB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .audio_trigger(audio_trigger),
    .clear_in(clear_in), .bypass_in(bypass_in), .signal_in(signal_in),
    .signal_out(signal_out), .out_valid(out_valid), .busy_out(busy_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int     checks = 0;
  int     errors = 0;
  longint mxp [NC];
  longint myp [NC];
  longint mout[NC];
  longint fx  [NC];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint obs_ch(input int c);
    logic signed [W-1:0] v;
    v = signal_out[c*W +: W];
    return longint'(v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      mxp[c] = 0; myp[c] = 0; mout[c] = 0;
    end
  endtask

  // Reference: y = (x - x_prev)*2^FB + y_prev - floor(y_prev/2^KS), clamped, output floored.
  task automatic model_step(input bit byp);
    longint acc, ymax, ymin;
    ymax = (longint'(1) <<< (W + FB - 1)) - 1;
    ymin = -(longint'(1) <<< (W + FB - 1));
    for (int c = 0; c < NC; c++) begin
      if (byp) begin
        mout[c] = fx[c]; myp[c] = 0;
      end else begin
        acc = (fx[c] - mxp[c]) * (longint'(1) <<< FB) + myp[c] - fdiv(myp[c], longint'(1) <<< KS);
        if (acc > ymax) acc = ymax;
        if (acc < ymin) acc = ymin;
        myp[c] = acc;
        mout[c] = fdiv(acc, longint'(1) <<< FB);
      end
      mxp[c] = fx[c];
    end
  endtask

  task automatic load_inputs();
    logic [63:0] tmp;
    for (int c = 0; c < NC; c++) begin
      tmp = fx[c];
      signal_in[c*W +: W] = tmp[W-1:0];
    end
  endtask

  // One frame: trigger, check busy, wait (bounded) for out_valid, compare against the model.
  task automatic run_frame(input bit byp);
    int n;
    load_inputs();
    bypass_in = byp;
    audio_trigger = 1'b1;
    @(negedge clk_in);
    audio_trigger = 1'b0;
    bypass_in = 1'b0;
    chk("busy", busy_out, 1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_in);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    chk("latency", n, NC);
    model_step(byp);
    for (int c = 0; c < NC; c++) chk($sformatf("out_ch%0d", c), obs_ch(c), mout[c]);
    @(negedge clk_in);
    chk("valid_pulse", out_valid, 0);
    chk("idle_after", busy_out, 0);
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    model_clear();
  endtask

  initial begin
    longint prev0, cur0, hi;
    int nv, first;
    logic signed [W-1:0] rx;
    model_clear();

    // Reset state
    #2;
    chk("rst_out", signal_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_overrun", overrun_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Step 0 -> 1000 on ch0, ch1 held at 0; long decay
    fx[0] = 1000; fx[1] = 0;
    run_frame(1'b0);
    chk("step_first", obs_ch(0), 1000);
    chk("ch1_zero", obs_ch(1), 0);
    prev0 = obs_ch(0);
    hi = 0;
    for (int f = 1; f < 1024; f++) begin
      run_frame(1'b0);
      cur0 = obs_ch(0);
      if (cur0 > prev0) hi++;
      if (obs_ch(1) != 0) hi++;
      prev0 = cur0;
    end
    chk("decay_monotone_ch1_zero", hi, 0);
    chk("decay_final", ((prev0 <= 1) && (prev0 >= -1)) ? 1 : 0, 1);

    // Clear zeroes outputs and history
    do_clear();
    chk("clr_out", signal_out, 0);
    chk("clr_overrun", overrun_out, 0);

    // Saturation: -32768 then 32767
    fx[0] = -32768; fx[1] = 5;
    run_frame(1'b0);
    chk("sat_neg", obs_ch(0), -32768);
    fx[0] = 32767; fx[1] = 5;
    run_frame(1'b0);
    chk("sat_pos", obs_ch(0), 32767);

    // Overrun: second trigger one cycle after the first
    fx[0] = 700; fx[1] = -900;
    load_inputs();
    audio_trigger = 1'b1;
    @(negedge clk_in);
    signal_in = '1;
    @(negedge clk_in);
    audio_trigger = 1'b0;
    nv = 0; first = 0;
    for (int i = 2; i <= 9; i++) begin
      if (out_valid) begin
        nv++;
        if (first == 0) first = i - 1;
      end
      @(negedge clk_in);
    end
    model_step(1'b0);
    chk("ovr_flag", overrun_out, 1);
    chk("ovr_one_valid", nv, 1);
    chk("ovr_latency", first, NC);
    for (int c = 0; c < NC; c++) chk($sformatf("ovr_out_ch%0d", c), obs_ch(c), mout[c]);
    do_clear();
    chk("ovr_cleared", overrun_out, 0);

    // Reset mid-frame at ch_idx=1
    fx[0] = 321; fx[1] = -123;
    run_frame(1'b0);
    fx[0] = 4000; fx[1] = 4000;
    load_inputs();
    audio_trigger = 1'b1;
    @(negedge clk_in);
    audio_trigger = 1'b0;
    @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_out", signal_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_valid", out_valid, 0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (out_valid) nv++;
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (out_valid) nv++;
    end
    chk("mid_rst_no_valid", nv, 0);
    model_clear();
    fx[0] = 500; fx[1] = -300;
    run_frame(1'b0);
    chk("post_rst_fresh", obs_ch(0), 500);

    // Bypass then leave bypass with the same sample
    fx[0] = 1234; fx[1] = -77;
    run_frame(1'b1);
    chk("bypass_pass", obs_ch(0), 1234);
    run_frame(1'b0);
    chk("bypass_exit", obs_ch(0), 0);

    // Randomized frames
    for (int f = 0; f < 200; f++) begin
      for (int c = 0; c < NC; c++) begin
        rx = W'($urandom);
        fx[c] = longint'(rx);
      end
      run_frame($urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
